// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   FQ_DEPTH / FQ_XLEN / FQ_INSTR_W : default geometry of fetch_queue
//   FQ_NOP                          : canonical RISC-V NOP (addi x0,x0,0)
//   FQ_PC_INC                       : sequential fetch stride in bytes
//   fq_state_e                      : fetch FSM states
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH   = 4;
  localparam int unsigned FQ_XLEN    = 64;
  localparam int unsigned FQ_INSTR_W = 32;

  localparam logic [31:0] FQ_NOP    = 32'h0000_0013;
  localparam int unsigned FQ_PC_INC = 4;

  // FETCH: every response belongs to a live request.
  // DRAIN: responses for requests issued before a redirect are still due.
  typedef enum logic {
    FQ_FETCH = 1'b0,
    FQ_DRAIN = 1'b1
  } fq_state_e;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous circular-buffer FIFO with push/pop/clear.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clear_i       : empties the FIFO (same effect as reset on pointers/count)
//   push_i/wdata_i: write request; ignored when full unless popping too
//   pop_i/rdata_o : read request; rdata_o always shows the head entry
//   count_o       : current occupancy (0..DEPTH)
//   full_o/empty_o: occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i && do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end feeding the IF/ID pipeline register.
//   clk, reset                      : clock, synchronous active-high reset
//   redirect_valid, redirect_pc     : branch/flush; highest priority after reset
//   imem_req_valid/addr/ready       : in-order fetch requests to instruction memory
//   imem_resp_valid/instr           : in-order responses, at most one per cycle
//   out_valid/pc/instr, out_ready   : {pc, instr} stream toward decode
// Request credits cover queued plus in-flight instructions so a response
// always finds room in the queue.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned      DEPTH    = FQ_DEPTH,
  parameter int unsigned      XLEN     = FQ_XLEN,
  parameter int unsigned      INSTR_W  = FQ_INSTR_W,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_instr,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fq_state_e         state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     drop_new;

  logic              credit_ok, req_fire, resp_live, resp_keep, resp_drop, pop;

  logic [CW-1:0]     q_count, tag_count;
  logic              q_full, q_empty, tag_full, tag_empty;
  logic [XLEN-1:0]   tag_pc;
  logic [XLEN+INSTR_W-1:0] q_rdata;

  assign credit_ok      = ({1'b0, q_count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid = ~reset & ~redirect_valid & credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response in a redirect cycle is stale by definition and never enqueued.
  assign resp_live = imem_resp_valid & ~redirect_valid & ~reset;
  assign resp_keep = resp_live & (state_q == FQ_FETCH);
  assign resp_drop = resp_live & (state_q == FQ_DRAIN);

  assign out_valid = ~q_empty & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign {out_pc, out_instr} = out_valid ? q_rdata : '0;

  // Requests still owed to us after a redirect, minus the one landing now.
  assign drop_new = outstanding_q - CW'(imem_resp_valid);

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (redirect_valid),
    .push_i  (req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (resp_keep),
    .rdata_o (tag_pc),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  sync_fifo #(
    .WIDTH (XLEN + INSTR_W),
    .DEPTH (DEPTH)
  ) u_instr_queue (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (redirect_valid),
    .push_i  (resp_keep),
    .wdata_i ({tag_pc, imem_resp_instr}),
    .pop_i   (pop),
    .rdata_o (q_rdata),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
    drop_cnt_d    = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_pc & PC_ALIGN_MASK;
      outstanding_d = drop_new;
      drop_cnt_d    = drop_new;
      state_d       = (drop_new != '0) ? FQ_DRAIN : FQ_FETCH;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(FQ_PC_INC);
      if (resp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
        if (drop_cnt_q == CW'(1)) state_d = FQ_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FQ_FETCH;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Credit accounting guarantees these never fire with a well-behaved memory.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(resp_keep && q_full));
      assert (!(resp_keep && tag_empty));
      assert (!(req_fire && tag_full));
      assert (tag_count <= outstanding_q);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_instr = '0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .XLEN     (64),
    .INSTR_W  (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_instr (imem_resp_instr),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_ready       (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: queued entries, live in-flight PCs, stale in-flight count.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        outq[$];
  logic [63:0] kept[$];
  int          stale = 0;
  logic [63:0] mpc = RESET_PC;
  bit          known = 0;
  bit          prev_rst = 0;

  // Memory: pending accepted addresses with their due cycle.
  logic [63:0] pend_addr[$];
  longint      pend_due[$];
  longint      cyc = 0;
  int          lat_min = 1, lat_max = 1;

  // Values sampled during the most recent step.
  logic        s_rv, s_ov;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic rst, input logic redir, input logic [63:0] rpc,
                      input logic ordy, input logic mrdy);
    logic resp, exp_rv, exp_ov, m_acc, d_acc, m_pop;
    logic [31:0] rinstr;
    logic [63:0] p;
    reset = rst;
    redirect_valid = redir;
    redirect_pc = rpc;
    out_ready = ordy;
    imem_req_ready = mrdy;
    resp = 1'b0;
    rinstr = '0;
    if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      resp = 1'b1;
      rinstr = memf(pend_addr[0]);
    end
    imem_resp_valid = resp;
    imem_resp_instr = rinstr;
    #1;
    s_rv = imem_req_valid; s_addr = imem_req_addr;
    s_ov = out_valid; s_pc = out_pc; s_instr = out_instr;

    exp_rv = !rst && !redir && ((outq.size() + kept.size() + stale) < DEPTH);
    exp_ov = (outq.size() > 0) && !redir;
    if (known) begin
      chk("req_valid", {63'b0, s_rv}, {63'b0, exp_rv});
      chk("req_addr", s_addr, mpc);
      chk("out_valid", {63'b0, s_ov}, {63'b0, exp_ov});
      if (exp_ov && s_ov) begin
        chk("out_pc", s_pc, outq[0].pc);
        chk("out_instr", {32'b0, s_instr}, {32'b0, outq[0].instr});
      end
      if (rst && prev_rst) begin
        chk("rst_out_pc", s_pc, 64'h0);
        chk("rst_out_instr", {32'b0, s_instr}, 64'h0);
      end
    end

    m_acc = exp_rv && mrdy;
    d_acc = s_rv && mrdy;
    m_pop = exp_ov && ordy;
    if (rst) begin
      outq.delete(); kept.delete(); stale = 0; mpc = RESET_PC;
      pend_addr.delete(); pend_due.delete();
      known = 1;
    end else begin
      if (resp) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (d_acc) begin
        pend_addr.push_back(s_addr);
        pend_due.push_back(cyc + longint'($urandom_range(lat_max, lat_min)));
      end
      if (known) begin
        if (redir) begin
          stale = stale + kept.size() - (resp ? 1 : 0);
          outq.delete(); kept.delete();
          mpc = {rpc[63:2], 2'b00};
        end else begin
          if (m_pop) void'(outq.pop_front());
          if (resp) begin
            if (stale > 0) stale--;
            else begin
              checks++;
              if (kept.size() == 0) begin
                failures++;
                $display("FAIL resp_pairing: got response with no live request (cycle %0d)", cyc);
              end else begin
                p = kept.pop_front();
                outq.push_back('{pc: p, instr: memf(p)});
              end
            end
          end
          if (m_acc) begin
            kept.push_back(mpc);
            mpc = mpc + 64'd4;
          end
        end
      end
    end
    prev_rst = rst;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic nstep(input logic ordy);
    step(1'b0, 1'b0, 64'h0, ordy, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        ordy;
    logic        rv;
    logic [63:0] addr;
    logic        ov;
    logic [63:0] pc;
  } vec_t;
  vec_t tv[14];

  initial begin
    int n, pops, ok;
    logic [63:0] got[$];

    tv[0]  = '{1'b1, 1'b1, 64'h00, 1'b0, 64'h00};
    tv[1]  = '{1'b1, 1'b1, 64'h04, 1'b0, 64'h00};
    tv[2]  = '{1'b1, 1'b1, 64'h08, 1'b1, 64'h00};
    tv[3]  = '{1'b1, 1'b1, 64'h0C, 1'b1, 64'h04};
    tv[4]  = '{1'b1, 1'b1, 64'h10, 1'b1, 64'h08};
    tv[5]  = '{1'b0, 1'b1, 64'h14, 1'b1, 64'h0C};
    tv[6]  = '{1'b0, 1'b1, 64'h18, 1'b1, 64'h0C};
    tv[7]  = '{1'b0, 1'b0, 64'h1C, 1'b1, 64'h0C};
    tv[8]  = '{1'b0, 1'b0, 64'h1C, 1'b1, 64'h0C};
    tv[9]  = '{1'b0, 1'b0, 64'h1C, 1'b1, 64'h0C};
    tv[10] = '{1'b1, 1'b0, 64'h1C, 1'b1, 64'h0C};
    tv[11] = '{1'b1, 1'b1, 64'h1C, 1'b1, 64'h10};
    tv[12] = '{1'b1, 1'b1, 64'h20, 1'b1, 64'h14};
    tv[13] = '{1'b1, 1'b1, 64'h24, 1'b1, 64'h18};

    @(posedge clk);
    #1;

    // Zero-wait memory: startup latency, streaming, stall and release.
    lat_min = 1; lat_max = 1;
    do_reset();
    chk("reset_req_valid", {63'b0, s_rv}, 64'h0);
    chk("reset_out_valid", {63'b0, s_ov}, 64'h0);
    for (int i = 0; i < 14; i++) begin
      nstep(tv[i].ordy);
      chk("tv_req_valid", {63'b0, s_rv}, {63'b0, tv[i].rv});
      chk("tv_req_addr", s_addr, tv[i].addr);
      chk("tv_out_valid", {63'b0, s_ov}, {63'b0, tv[i].ov});
      if (tv[i].ov) begin
        chk("tv_out_pc", s_pc, tv[i].pc);
        chk("tv_out_instr", {32'b0, s_instr}, {32'b0, memf(tv[i].pc)});
      end
    end

    // Stall from reset: exactly DEPTH requests, then in-order drain.
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      nstep(1'b0);
      if (s_rv) n++;
    end
    chk("stall_req_count", 64'(n), 64'd4);
    chk("stall_req_valid_low", {63'b0, s_rv}, 64'h0);
    got.delete();
    for (int i = 0; i < 10; i++) begin
      nstep(1'b1);
      if (s_ov) got.push_back(s_pc);
    end
    chk("drain_len_ge4", 64'(got.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("drain_order", got[i], 64'(i * 4));

    // Latency 4, three in flight, redirect to 0x100.
    lat_min = 4; lat_max = 4;
    do_reset();
    nstep(1'b1); nstep(1'b1); nstep(1'b1);
    step(1'b0, 1'b1, 64'h100, 1'b1, 1'b1);
    chk("redir_req_valid", {63'b0, s_rv}, 64'h0);
    nstep(1'b1);
    chk("redir_first_addr", s_addr, 64'h100);
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      nstep(1'b1);
      if (s_ov) begin
        ok = 1;
        chk("drain_first_pc", s_pc, 64'h100);
      end
    end
    if (ok == 0) chk("drain_timeout", 64'd0, 64'd1);

    // Redirect coinciding with a response while decode is ready.
    lat_min = 2; lat_max = 2;
    do_reset();
    for (int i = 0; i < 6; i++) nstep(1'b1);
    ok = 0;
    for (int i = 0; i < 10 && ok == 0; i++) begin
      if (pend_due.size() > 0 && pend_due[0] <= cyc && outq.size() > 0) begin
        ok = 1;
        step(1'b0, 1'b1, 64'h203, 1'b1, 1'b1);
        chk("redir_resp_out_valid", {63'b0, s_ov}, 64'h0);
        nstep(1'b1);
        chk("redir_align_addr", s_addr, 64'h200);
      end else nstep(1'b1);
    end
    if (ok == 0) chk("redir_resp_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 10; i++) nstep(1'b1);

    // PC wrap at the top of the address space.
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1);
    nstep(1'b1);
    chk("wrap_addr0", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    nstep(1'b1);
    chk("wrap_addr1", s_addr, 64'h0);
    for (int i = 0; i < 8; i++) nstep(1'b1);

    // Reset with a full queue.
    do_reset();
    for (int i = 0; i < 8; i++) nstep(1'b0);
    chk("full_out_valid", {63'b0, s_ov}, 64'h1);
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    chk("fullrst_out_valid", {63'b0, s_ov}, 64'h0);
    chk("fullrst_req_valid", {63'b0, s_rv}, 64'h0);

    // Reset while draining stale responses; fetch must restart cleanly.
    lat_min = 4; lat_max = 4;
    do_reset();
    nstep(1'b1); nstep(1'b1); nstep(1'b1);
    step(1'b0, 1'b1, 64'h300, 1'b1, 1'b1);
    nstep(1'b1);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("drainrst_out_valid", {63'b0, s_ov}, 64'h0);
    chk("drainrst_req_valid", {63'b0, s_rv}, 64'h0);
    lat_min = 1; lat_max = 1;
    nstep(1'b1);
    chk("drainrst_resume_addr", s_addr, RESET_PC);
    nstep(1'b1);
    nstep(1'b1);
    chk("drainrst_first_valid", {63'b0, s_ov}, 64'h1);
    chk("drainrst_first_pc", s_pc, RESET_PC);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      logic r, rd, ordy, mrdy;
      logic [63:0] rpc;
      if (i % 500 == 0) begin
        lat_min = int'($urandom_range(3, 1));
        lat_max = lat_min + int'($urandom_range(2, 0));
      end
      r    = ($urandom_range(299, 0) == 0);
      rd   = ($urandom_range(24, 0) == 0);
      ordy = ($urandom_range(9, 0) < 7);
      mrdy = ($urandom_range(3, 0) != 0);
      rpc  = {$urandom, $urandom};
      if ($urandom_range(3, 0) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31, 0));
      step(r, rd, rpc, ordy, mrdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
